// File: rtl/scan_point_packer.sv
// Scan point packer: collects {dist,rssi} of resampled points into two
// ping-pong banks and streams each full bank as a checksummed byte packet
// over a valid/ready link.
module scan_point_packer #(
  parameter int unsigned PKT_POINTS = 90,
  parameter logic [7:0]  HDR0       = 8'hA5,
  parameter logic [7:0]  HDR1       = 8'h5A
) (
  input  logic        i_clk_50m,
  input  logic        i_rst,
  input  logic        i_dist_sig,
  input  logic [15:0] i_code_angle,
  input  logic [63:0] i_edge_data,
  input  logic        i_flush,
  input  logic        i_tx_ready,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_sop,
  output logic        o_tx_eop,
  output logic        o_pkt_busy,
  output logic        o_drop
);

  localparam int unsigned   DEPTH      = 2 * PKT_POINTS;
  localparam int unsigned   AW         = $clog2(DEPTH);
  localparam logic [7:0]    LAST_IDX   = 8'(PKT_POINTS - 1);
  localparam logic [AW-1:0] BANK1_BASE = AW'(PKT_POINTS);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_ANG_H, S_ANG_L, S_CNT, S_PAYLOAD, S_CSUM
  } state_t;

  // Byte lane of a stored point word {dist, rssi}, most significant first.
  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [AW-1:0] bank_base(input logic bank);
    return bank ? BANK1_BASE : '0;
  endfunction

  logic [31:0]      bank_mem [0:DEPTH-1];
  logic [31:0]      rd_word_q;

  state_t           state_q, state_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             sop_q, sop_d, eop_q, eop_d;
  logic             drop_q, drop_d;
  logic [7:0]       csum_q, csum_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [7:0]       pt_idx_q, pt_idx_d;
  logic             rd_bank_q, rd_bank_d;
  logic             wr_bank_q, wr_bank_d;
  logic [7:0]       fill_q, fill_d;
  logic [1:0]       full_q, full_d;
  logic [1:0][7:0]  cnt_q, cnt_d;
  logic [1:0][15:0] angle_q, angle_d;

  logic             adv, release_bank, load_byte, rd_en, wr_en;
  logic             wr_free, accept, commit;
  logic [7:0]       nxt_byte, fill_n, cur_cnt, pt_next;
  logic [15:0]      cur_ang;
  logic [AW-1:0]    rd_addr, wr_addr;
  logic             unused_edge;

  assign unused_edge = ^i_edge_data[63:32];
  assign cur_cnt     = cnt_q[rd_bank_q];
  assign cur_ang     = angle_q[rd_bank_q];
  assign pt_next     = pt_idx_q + 8'd1;
  assign wr_addr     = bank_base(wr_bank_q) + AW'(fill_q);

  // Next-state logic for the TX byte sequencer and the bank write side.
  always_comb begin
    state_d      = state_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    sop_d        = sop_q;
    eop_d        = eop_q;
    csum_d       = csum_q;
    byte_idx_d   = byte_idx_q;
    pt_idx_d     = pt_idx_q;
    rd_bank_d    = rd_bank_q;
    wr_bank_d    = wr_bank_q;
    fill_d       = fill_q;
    full_d       = full_q;
    cnt_d        = cnt_q;
    angle_d      = angle_q;
    release_bank = 1'b0;
    load_byte    = 1'b0;
    nxt_byte     = 8'h00;
    rd_en        = 1'b0;
    rd_addr      = bank_base(rd_bank_q);

    // The output register may take a new byte when empty or being accepted.
    adv = !tx_valid_q || i_tx_ready;
    if (adv) begin
      case (state_q)
        S_IDLE: begin
          if (full_q[rd_bank_q]) begin
            state_d    = S_HDR0;
            tx_valid_d = 1'b1;
            tx_data_d  = HDR0;
            sop_d      = 1'b1;
            csum_d     = HDR0;
            rd_en      = 1'b1;   // prefetch point 0 during the header
          end
        end
        S_HDR0:  begin state_d = S_HDR1;  nxt_byte = HDR1;          load_byte = 1'b1; sop_d = 1'b0; end
        S_HDR1:  begin state_d = S_ANG_H; nxt_byte = cur_ang[15:8]; load_byte = 1'b1; end
        S_ANG_H: begin state_d = S_ANG_L; nxt_byte = cur_ang[7:0];  load_byte = 1'b1; end
        S_ANG_L: begin state_d = S_CNT;   nxt_byte = cur_cnt;       load_byte = 1'b1; end
        S_CNT: begin
          state_d    = S_PAYLOAD;
          byte_idx_d = 2'd0;
          pt_idx_d   = 8'd0;
          nxt_byte   = pick_byte(rd_word_q, 2'd0);
          load_byte  = 1'b1;
        end
        S_PAYLOAD: begin
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
            nxt_byte   = pick_byte(rd_word_q, byte_idx_q + 2'd1);
            load_byte  = 1'b1;
            // The last lane is captured at the same edge the next word lands.
            if (byte_idx_q == 2'd2 && pt_next != cur_cnt) begin
              rd_en   = 1'b1;
              rd_addr = bank_base(rd_bank_q) + AW'(pt_next);
            end
          end else if (pt_next == cur_cnt) begin
            state_d   = S_CSUM;
            tx_data_d = csum_q;
            eop_d     = 1'b1;
          end else begin
            pt_idx_d   = pt_next;
            byte_idx_d = 2'd0;
            nxt_byte   = pick_byte(rd_word_q, 2'd0);
            load_byte  = 1'b1;
          end
        end
        S_CSUM: begin
          state_d      = S_IDLE;
          tx_valid_d   = 1'b0;
          eop_d        = 1'b0;
          release_bank = 1'b1;
          rd_bank_d    = ~rd_bank_q;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (load_byte) begin
      tx_data_d = nxt_byte;
      csum_d    = csum_q ^ nxt_byte;
    end

    // A bank released this cycle can take a point in the same cycle.
    if (release_bank) full_d[rd_bank_q] = 1'b0;
    wr_free = !full_q[wr_bank_q] || (release_bank && (rd_bank_q == wr_bank_q));
    accept  = i_dist_sig && wr_free;
    drop_d  = i_dist_sig && !wr_free;
    wr_en   = accept;
    fill_n  = fill_q;
    if (accept) begin
      if (fill_q == 8'd0) angle_d[wr_bank_q] = i_code_angle;
      fill_n = fill_q + 8'd1;
    end

    commit = (accept && (fill_q == LAST_IDX)) || (i_flush && (fill_n != 8'd0));
    if (commit) begin
      full_d[wr_bank_q] = 1'b1;
      cnt_d[wr_bank_q]  = fill_n;
      wr_bank_d         = ~wr_bank_q;
      fill_d            = 8'd0;
    end else begin
      fill_d = fill_n;
    end
  end

  // State registers; reset covers control and the visible outputs.
  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      drop_q     <= 1'b0;
      byte_idx_q <= 2'd0;
      pt_idx_q   <= 8'd0;
      rd_bank_q  <= 1'b0;
      wr_bank_q  <= 1'b0;
      fill_q     <= 8'd0;
      full_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      drop_q     <= drop_d;
      byte_idx_q <= byte_idx_d;
      pt_idx_q   <= pt_idx_d;
      rd_bank_q  <= rd_bank_d;
      wr_bank_q  <= wr_bank_d;
      fill_q     <= fill_d;
      full_q     <= full_d;
    end
    csum_q  <= csum_d;
    cnt_q   <= cnt_d;
    angle_q <= angle_d;
  end

  // Bank RAM: one write port from the point stream, one synchronous read port.
  always_ff @(posedge i_clk_50m) begin
    if (wr_en) bank_mem[wr_addr] <= i_edge_data[31:0];
    if (rd_en) rd_word_q <= bank_mem[rd_addr];
  end

  assign o_tx_valid = tx_valid_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_sop   = sop_q;
  assign o_tx_eop   = eop_q;
  assign o_drop     = drop_q;
  assign o_pkt_busy = (|full_q) || (state_q != S_IDLE);

endmodule

// File: tb/tb_scan_point_packer.sv
// Bench for scan_point_packer with 4-point packets: directed vector table,
// hand-written corner sequences and a randomized run against a packet model.
module tb_scan_point_packer;
  localparam int PKT = 4;

  logic        clk = 1'b0;
  logic        rst, dist_sig, flush, tx_ready;
  logic [15:0] code_angle;
  logic [63:0] edge_data;
  logic        tx_valid, tx_sop, tx_eop, pkt_busy, drop;
  logic [7:0]  tx_data;

  always #10 clk = ~clk;

  scan_point_packer #(.PKT_POINTS(PKT)) dut (
    .i_clk_50m   (clk),
    .i_rst       (rst),
    .i_dist_sig  (dist_sig),
    .i_code_angle(code_angle),
    .i_edge_data (edge_data),
    .i_flush     (flush),
    .i_tx_ready  (tx_ready),
    .o_tx_valid  (tx_valid),
    .o_tx_data   (tx_data),
    .o_tx_sop    (tx_sop),
    .o_tx_eop    (tx_eop),
    .o_pkt_busy  (pkt_busy),
    .o_drop      (drop)
  );

  typedef struct { logic [7:0] d; logic sop; logic eop; } sb_t;
  typedef struct { int npts; bit flush_last; int rmode; logic [7:0] exp_cnt; int exp_len; logic [7:0] exp_csum; } vec_t;

  int          errors = 0, checks = 0;
  int          pkt_cnt = 0, drop_cnt = 0, rdy_mode = 0;
  sb_t         exp_q[$];
  logic [7:0]  rx_cur[$];
  logic [7:0]  last_pkt[$];
  logic [31:0] m_pts[$];
  logic [15:0] m_angle = 16'h0;
  int          m_held = 0, held_eff;
  logic        exp_drop = 1'b0, prev_stall = 1'b0, rel, took;
  logic [9:0]  prev_out = 10'h0;
  sb_t         mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] pt_word(input int k);
    return {8'(2*k+1), 8'(2*k+2), 8'(10+2*k), 8'(11+2*k)};
  endfunction

  // Reference: turn the collected points into the expected byte stream.
  task automatic model_commit();
    logic [7:0] b[$];
    logic [7:0] x;
    sb_t e;
    b.push_back(8'hA5); b.push_back(8'h5A);
    b.push_back(m_angle[15:8]); b.push_back(m_angle[7:0]);
    b.push_back(8'(m_pts.size()));
    foreach (m_pts[i]) begin
      b.push_back(m_pts[i][31:24]); b.push_back(m_pts[i][23:16]);
      b.push_back(m_pts[i][15:8]);  b.push_back(m_pts[i][7:0]);
    end
    x = 8'h00;
    foreach (b[i]) x = x ^ b[i];
    b.push_back(x);
    foreach (b[i]) begin
      e.d = b[i]; e.sop = (i == 0); e.eop = (i == b.size() - 1);
      exp_q.push_back(e);
    end
    m_pts.delete();
    m_held++;
  endtask

  // Monitor and model, evaluated half a cycle before the edge that consumes them.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete(); rx_cur.delete(); m_pts.delete();
      m_held = 0; exp_drop = 1'b0; prev_stall = 1'b0;
    end else begin
      chk("drop", 32'(drop), 32'(exp_drop));
      if (drop) drop_cnt++;
      if (prev_stall)
        chk("stall_hold", 32'({tx_valid, tx_sop, tx_eop, tx_data}), 32'({1'b1, prev_out}));
      prev_stall = tx_valid && !tx_ready;
      prev_out   = {tx_sop, tx_eop, tx_data};
      rel = 1'b0;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte: got 0x%0h, required no byte", tx_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("tx_byte", 32'({tx_sop, tx_eop, tx_data}), 32'({mon_e.sop, mon_e.eop, mon_e.d}));
        end
        rx_cur.push_back(tx_data);
        if (tx_eop) begin
          last_pkt = rx_cur; rx_cur.delete(); pkt_cnt++; rel = 1'b1;
        end
      end
      held_eff = m_held - (rel ? 1 : 0);
      exp_drop = 1'b0; took = 1'b0;
      if (dist_sig) begin
        if (m_pts.size() == 0 && held_eff >= 2) exp_drop = 1'b1;
        else begin
          if (m_pts.size() == 0) m_angle = code_angle;
          m_pts.push_back(edge_data[31:0]);
          took = 1'b1;
        end
      end
      m_held = held_eff;
      if ((took && m_pts.size() == PKT) || (flush && m_pts.size() > 0)) model_commit();
    end
  end

  // Sink ready pattern: 0 steady, 1 toggling, 2 stalled, 3 random.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        2:       tx_ready = 1'b0;
        default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send_point(input logic [15:0] ang, input logic [31:0] w, input logic fl);
    dist_sig = 1'b1; code_angle = ang; edge_data = {$urandom(), w}; flush = fl;
    @(posedge clk); #1;
    dist_sig = 1'b0; flush = 1'b0;
  endtask

  task automatic wait_pkts(input int target, input int budget);
    int n = 0;
    while (pkt_cnt < target && n < budget) begin @(posedge clk); #1; n++; end
    chk("pkt_wait", 32'(pkt_cnt >= target), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[4];
    int   base, drop_base, n;
    logic seen;
    rst = 1'b1; dist_sig = 1'b0; flush = 1'b0; code_angle = 16'h0; edge_data = 64'h0;
    vecs[0] = '{4, 1'b0, 0, 8'h04, 22, 8'h97};
    vecs[1] = '{4, 1'b0, 1, 8'h04, 22, 8'h97};
    vecs[2] = '{3, 1'b1, 0, 8'h03, 18, 8'h9E};
    vecs[3] = '{1, 1'b1, 1, 8'h01, 10, 8'h98};

    repeat (3) @(posedge clk); #1;
    chk("rst_valid", 32'(tx_valid), 0);
    chk("rst_sop",   32'(tx_sop),   0);
    chk("rst_eop",   32'(tx_eop),   0);
    chk("rst_busy",  32'(pkt_busy), 0);
    chk("rst_drop",  32'(drop),     0);
    chk("rst_data",  32'(tx_data),  0);
    rst = 1'b0;

    foreach (vecs[r]) begin
      rdy_mode = vecs[r].rmode;
      repeat (2) @(posedge clk); #1;
      base = pkt_cnt;
      for (int k = 0; k < vecs[r].npts; k++)
        send_point(16'(100 + k), pt_word(k), vecs[r].flush_last && (k == vecs[r].npts - 1));
      wait_pkts(base + 1, 200);
      chk($sformatf("v%0d_len", r),   32'(last_pkt.size()), 32'(vecs[r].exp_len));
      chk($sformatf("v%0d_cnt", r),   32'(last_pkt[4]), 32'(vecs[r].exp_cnt));
      chk($sformatf("v%0d_ang", r),   32'({last_pkt[2], last_pkt[3]}), 32'd100);
      chk($sformatf("v%0d_csum", r),  32'(last_pkt[last_pkt.size() - 1]), 32'(vecs[r].exp_csum));
      repeat (4) @(posedge clk); #1;
      chk($sformatf("v%0d_idle", r),  32'(pkt_busy), 0);
    end

    // Both banks committed while stalled; the ninth point has nowhere to go.
    rdy_mode = 2;
    repeat (3) @(posedge clk); #1;
    base = pkt_cnt; drop_base = drop_cnt;
    for (int k = 0; k < 9; k++) send_point(16'(200 + k), $urandom(), 1'b0);
    repeat (3) @(posedge clk); #1;
    chk("drop_pulses",  32'(drop_cnt - drop_base), 32'd1);
    chk("busy_stalled", 32'(pkt_busy), 32'd1);
    chk("no_pkt_stall", 32'(pkt_cnt - base), 0);
    rdy_mode = 0;
    wait_pkts(base + 2, 300);
    chk("order_angle", 32'({last_pkt[2], last_pkt[3]}), 32'd204);
    chk("order_cnt",   32'(last_pkt[4]), 32'd4);

    // Flush with nothing pending.
    repeat (4) @(posedge clk); #1;
    base = pkt_cnt;
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; seen = seen | pkt_busy; end
    chk("flush_empty_busy", 32'(seen), 0);
    chk("flush_empty_pkt",  32'(pkt_cnt - base), 0);

    // Reset in the middle of the payload, then a clean packet.
    base = pkt_cnt;
    for (int k = 0; k < 4; k++) send_point(16'(100 + k), pt_word(k), 1'b0);
    n = 0;
    while (rx_cur.size() < 8 && n < 200) begin @(posedge clk); #1; n++; end
    chk("reach_payload", 32'(rx_cur.size() >= 8), 32'd1);
    rst = 1'b1; @(posedge clk); #1;
    chk("rst_mid_valid", 32'(tx_valid), 0);
    chk("rst_mid_eop",   32'(tx_eop),   0);
    chk("rst_mid_busy",  32'(pkt_busy), 0);
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_mid_nopkt", 32'(pkt_cnt - base), 0);
    for (int k = 0; k < 4; k++) send_point(16'(100 + k), pt_word(k), 1'b0);
    wait_pkts(base + 1, 200);
    chk("after_rst_len",  32'(last_pkt.size()), 32'd22);
    chk("after_rst_cnt",  32'(last_pkt[4]), 32'd4);
    chk("after_rst_csum", 32'(last_pkt[last_pkt.size() - 1]), 32'h97);

    // Randomized traffic against the model, including drops and flushes.
    rdy_mode = 3;
    base = pkt_cnt;
    for (int c = 0; c < 1500; c++) begin
      dist_sig   = ($urandom_range(0, 9) < 4);
      code_angle = 16'($urandom());
      edge_data  = {$urandom(), $urandom()};
      flush      = ($urandom_range(0, 19) == 0);
      @(posedge clk); #1;
    end
    dist_sig = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    rdy_mode = 0;
    n = 0;
    while ((exp_q.size() != 0 || rx_cur.size() != 0) && n < 3000) begin @(posedge clk); #1; n++; end
    chk("rand_drain",  32'(exp_q.size()), 0);
    chk("rand_pkts",   32'(pkt_cnt - base > 10), 32'd1);
    repeat (4) @(posedge clk); #1;
    chk("rand_idle",   32'(pkt_busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
